pipe_ctrl_unit: RTL

//   Decoded, pipelined control path for the 5-stage RV32 core. Decodes the ID-stage opcode into a control

---
 rtl/pipe_ctrl_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Control path for a 5-stage RV32 pipeline. It decodes the ID opcode, stages the control bundle through
// ID/EX, EX/MEM and MEM/WB, stalls once on a load-use hazard, flushes IF on a taken branch and tracks illegal opcodes.
module pipe_ctrl_unit #(
  parameter int RA_W      = 5,
  parameter bit EXT_OPS   = 1'b0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [6:0]           op_i,
  input  logic [RA_W-1:0]      rs1_i,
  input  logic [RA_W-1:0]      rs2_i,
  input  logic [RA_W-1:0]      rd_i,
  input  logic                 br_eq_i,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 if_flush_o,
  output logic [1:0]           ex_alu_op_o,
  output logic                 ex_alu_src_o,
  output logic [RA_W-1:0]      ex_rd_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [RA_W-1:0]      mem_rd_o,
  output logic                 wb_reg_write_o,
  output logic                 wb_mem_to_reg_o,
  output logic [RA_W-1:0]      wb_rd_o,
  output logic                 illegal_o,
  output logic [ERR_CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  ctrl_t           id_ctrl;
  logic [RA_W-1:0] id_rd;
  logic            id_valid;
  logic            id_illegal;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            is_beq;
  logic            is_jal;
  logic            stall;

  // EX/MEM and MEM/WB carry only the fields consumed downstream.
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;
  logic            mem_reg_write;
  logic            mem_mem_to_reg;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    id_ctrl    = '0;
    id_valid   = 1'b0;
    id_illegal = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    is_beq     = 1'b0;
    is_jal     = 1'b0;
    case (op_i)
      OP_NOP: ;
      OP_R: begin
        id_ctrl.alu_op    = 2'b10;
        id_ctrl.reg_write = 1'b1;
        id_valid = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_valid = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_LD: begin
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_valid = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_SD: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_valid = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        id_ctrl.alu_op = 2'b01;
        id_valid = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_beq   = 1'b1;
      end
      OP_LUI: begin
        if (EXT_OPS) begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_valid = 1'b1;
        end else begin
          id_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        if (EXT_OPS) begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_valid = 1'b1;
          is_jal   = 1'b1;
        end else begin
          id_illegal = 1'b1;
        end
      end
      default: id_illegal = 1'b1;
    endcase
    id_rd = id_valid ? rd_i : '0;
  end

  assign stall = ex_mem_read && (ex_rd_o != '0) &&
                 (((ex_rd_o == rs1_i) && uses_rs1) || ((ex_rd_o == rs2_i) && uses_rs2));

  assign pc_write_o   = ~stall;
  assign ifid_write_o = ~stall;
  assign if_flush_o   = ~rst_i & ~stall & ((is_beq & br_eq_i) | is_jal);

  // NOTE: all pipeline state uses non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_alu_op_o     <= '0;
      ex_alu_src_o    <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_rd_o         <= '0;
      mem_read_o      <= 1'b0;
      mem_write_o     <= 1'b0;
      mem_reg_write   <= 1'b0;
      mem_mem_to_reg  <= 1'b0;
      mem_rd_o        <= '0;
      wb_reg_write_o  <= 1'b0;
      wb_mem_to_reg_o <= 1'b0;
      wb_rd_o         <= '0;
      illegal_o       <= 1'b0;
      illegal_cnt_o   <= '0;
    end else begin
      // A stalled ID instruction stays in IF/ID and a bubble enters ID/EX.
      ex_alu_op_o   <= stall ? 2'b00 : id_ctrl.alu_op;
      ex_alu_src_o  <= ~stall & id_ctrl.alu_src;
      ex_mem_read   <= ~stall & id_ctrl.mem_read;
      ex_mem_write  <= ~stall & id_ctrl.mem_write;
      ex_reg_write  <= ~stall & id_ctrl.reg_write;
      ex_mem_to_reg <= ~stall & id_ctrl.mem_to_reg;
      ex_rd_o       <= stall ? '0 : id_rd;

      mem_read_o     <= ex_mem_read;
      mem_write_o    <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_rd_o       <= ex_rd_o;

      wb_reg_write_o  <= mem_reg_write;
      wb_mem_to_reg_o <= mem_mem_to_reg;
      wb_rd_o         <= mem_rd_o;

      if (id_illegal && !stall) begin
        illegal_o <= 1'b1;
        if (illegal_cnt_o != '1) illegal_cnt_o <= illegal_cnt_o + 1'b1;
      end
    end
  end

endmodule
